irq_pending_latch: RTL and testbench

Upstream stage of the 8-to-3 priority encoder. It turns eight level request lines into sticky pending bits by rising-edge detection. It applies a per-line mask and presents the masked pending vector to the encoder's 8-bit input. It clears a bit when the consumer acknowledges the 3-bit index the encoder produced, and flags requests lost because their line was already pending.

---
 rtl/irq_pending_latch.sv | 57 +++++
 tb/tb_irq_pending_latch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Sticky rising-edge request latch feeding the 8-to-3 priority encoder.
// Tracks masked pending lines, acknowledge clears and per-line lost-request flags.
module irq_pending_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req_in,
  input  logic       mask_we,
  input  logic [7:0] mask_in,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  input  logic       clear_ovf,
  output logic [7:0] pending,
  output logic       irq,
  output logic [7:0] overflow
);

  logic [7:0] r_req_d;
  logic [7:0] r_pending_raw;
  logic [7:0] r_mask;
  logic [7:0] r_overflow;

  logic [7:0] w_edge;
  logic [7:0] w_clr;
  logic [7:0] w_new_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      assign w_edge[gi]    = req_in[gi] & ~r_req_d[gi];
      assign w_clr[gi]     = ack & (ack_idx == 3'(gi));
      // A re-request on the line being acked this edge is legal, not a loss.
      assign w_new_ovf[gi] = w_edge[gi] & r_pending_raw[gi] & ~w_clr[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_d       <= 8'h00;
      r_pending_raw <= 8'h00;
      r_mask        <= 8'h00;
      r_overflow    <= 8'h00;
    end else begin
      r_req_d       <= req_in;
      r_pending_raw <= (r_pending_raw & ~w_clr) | w_edge;
      if (mask_we) begin
        r_mask <= mask_in;
      end
      r_overflow    <= clear_ovf ? w_new_ovf : (r_overflow | w_new_ovf);
    end
  end

  // Outputs depend on registers only, so the encoder sees no input-to-output path.
  assign pending  = r_pending_raw & ~r_mask;
  assign irq      = |pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench for irq_pending_latch: stimulus pushes expected outputs,
// a monitor pops and compares them after each clock edge or on request.
module tb_irq_pending_latch;

  logic       clk;
  logic       reset;
  logic [7:0] req_in;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       ack;
  logic [2:0] ack_idx;
  logic       clear_ovf;
  logic [7:0] pending;
  logic       irq;
  logic [7:0] overflow;

  logic       mon_kick;
  int         n_checks;
  int         n_errors;

  logic [16:0] q_exp[$];
  string       q_name[$];

  irq_pending_latch dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .ack       (ack),
    .ack_idx   (ack_idx),
    .clear_ovf (clear_ovf),
    .pending   (pending),
    .irq       (irq),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string name, input logic [7:0] e_pend, input logic [7:0] e_ovf);
    q_exp.push_back({e_pend, |e_pend, e_ovf});
    q_name.push_back(name);
  endtask

  // One cycle of stimulus: drive at the falling edge, expect the result after the next rising edge.
  task automatic step(input string name, input logic [7:0] r, input logic mwe, input logic [7:0] m,
                      input logic a, input logic [2:0] idx, input logic cov,
                      input logic [7:0] e_pend, input logic [7:0] e_ovf);
    @(negedge clk);
    reset     = 1'b0;
    req_in    = r;
    mask_we   = mwe;
    mask_in   = m;
    ack       = a;
    ack_idx   = idx;
    clear_ovf = cov;
    push_exp(name, e_pend, e_ovf);
  endtask

  // Monitor: compare the oldest expectation whenever an output sample point arrives.
  initial begin
    logic [16:0] e;
    string       nm;
    forever begin
      @(posedge clk or posedge mon_kick);
      #1;
      if (q_exp.size() > 0) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        n_checks++;
        if (pending !== e[16:9]) begin
          n_errors++;
          $display("FAIL %s pending got %02h want %02h", nm, pending, e[16:9]);
        end
        n_checks++;
        if (irq !== e[8]) begin
          n_errors++;
          $display("FAIL %s irq got %0b want %0b", nm, irq, e[8]);
        end
        n_checks++;
        if (overflow !== e[7:0]) begin
          n_errors++;
          $display("FAIL %s overflow got %02h want %02h", nm, overflow, e[7:0]);
        end
        $display("txn %-12s pending=%02h irq=%0b overflow=%02h", nm, pending, irq, overflow);
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    mon_kick  = 1'b0;
    reset     = 1'b1;
    req_in    = 8'h00;
    mask_we   = 1'b0;
    mask_in   = 8'h00;
    ack       = 1'b0;
    ack_idx   = 3'd0;
    clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    push_exp("rst_init", 8'h00, 8'h00);

    //    name           req    mwe  mask  ack  idx  cov  pend   ovf
    step("set_90",      8'h90, 0, 8'h00, 0, 3'd0, 0, 8'h90, 8'h00);
    for (int i = 0; i < 5; i++)
      step("hold_90",   8'h90, 0, 8'h00, 0, 3'd0, 0, 8'h90, 8'h00);
    step("ack7",        8'h00, 0, 8'h00, 1, 3'd7, 0, 8'h10, 8'h00);
    step("ack4",        8'h00, 0, 8'h00, 1, 3'd4, 0, 8'h00, 8'h00);
    step("ack_idle2",   8'h00, 0, 8'h00, 1, 3'd2, 0, 8'h00, 8'h00);
    step("set2",        8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h04, 8'h00);
    step("drop2",       8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h04, 8'h00);
    step("ovf2",        8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h04, 8'h04);
    step("clr_ovf",     8'h04, 0, 8'h00, 0, 3'd0, 1, 8'h04, 8'h00);
    step("drop2b",      8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h04, 8'h00);
    step("clr_ovf_new", 8'h04, 0, 8'h00, 0, 3'd0, 1, 8'h04, 8'h04);
    step("drop2c",      8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h04, 8'h04);
    step("set6",        8'h40, 0, 8'h00, 0, 3'd0, 0, 8'h44, 8'h04);
    step("drop6",       8'h00, 0, 8'h00, 0, 3'd0, 0, 8'h44, 8'h04);
    step("reack6",      8'h40, 0, 8'h00, 1, 3'd6, 0, 8'h44, 8'h04);
    step("mask_ff",     8'h00, 1, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h04);
    step("unmask",      8'h00, 1, 8'h00, 0, 3'd0, 0, 8'h44, 8'h04);
    step("mask_ff2",    8'h00, 1, 8'hFF, 0, 3'd0, 0, 8'h00, 8'h04);
    step("ack_masked2", 8'h00, 0, 8'h00, 1, 3'd2, 0, 8'h00, 8'h04);
    step("unmask2",     8'h00, 1, 8'h00, 0, 3'd0, 0, 8'h40, 8'h04);
    step("reset2",      8'h04, 0, 8'h00, 0, 3'd0, 0, 8'h44, 8'h04);
    step("mask_0f",     8'h04, 1, 8'h0F, 0, 3'd0, 0, 8'h40, 8'h04);

    // Asynchronous reset in the middle of a cycle, with line 0 high.
    @(negedge clk);
    #3;
    req_in  = 8'h01;
    mask_we = 1'b0;
    reset   = 1'b1;
    push_exp("async_rst", 8'h00, 8'h00);
    mon_kick = 1'b1;
    #1 mon_kick = 1'b0;

    step("rel_01",      8'h01, 0, 8'h00, 0, 3'd0, 0, 8'h01, 8'h00);
    step("hold_01",     8'h01, 0, 8'h00, 0, 3'd0, 0, 8'h01, 8'h00);

    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(posedge clk);
    #2;
    if (q_exp.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain %0d expectations left, want 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
